// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
//   state_t   - FSM encoding (IDLE / RUN / DONE), 2 bits
//   ALL_ONES  - wide all-ones vector, sliced to DEND_W for the divide-by-zero quotient
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] ALL_ONES = {MAX_W{1'b1}};

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   partial_rem [SOR_W-1:0] in  - current partial remainder (always < sor)
//   dend_bit                in  - next dividend bit, MSB first
//   sor         [SOR_W-1:0] in  - divisor
//   quo_bit                 out - resulting quotient bit
//   next_rem    [SOR_W-1:0] out - partial remainder after this step
module div_step
    import div_pkg::*;
#(
    parameter int SOR_W = 4
) (
    input  logic [SOR_W-1:0] partial_rem,
    input  logic             dend_bit,
    input  logic [SOR_W-1:0] sor,
    output logic             quo_bit,
    output logic [SOR_W-1:0] next_rem
);

    logic [SOR_W:0] trial_s;
    logic [SOR_W:0] diff_s;

    assign trial_s = {partial_rem, dend_bit};
    assign diff_s  = trial_s - {1'b0, sor};
    assign quo_bit = (trial_s >= {1'b0, sor});
    // The difference is below sor whenever it is taken, so its top bit is zero.
    assign next_rem = quo_bit ? diff_s[SOR_W-1:0] : trial_s[SOR_W-1:0];

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk                  in  - rising-edge clock
//   rst                  in  - synchronous active-high reset
//   start                in  - request, accepted only while busy=0
//   dend     [DEND_W-1:0] in  - dividend, sampled on accepted start
//   sor      [SOR_W-1:0]  in  - divisor, sampled on accepted start
//   busy                 out - iterations in progress
//   done                 out - one-cycle pulse, results valid
//   quo      [DEND_W-1:0] out - quotient, held until the next result
//   rem      [SOR_W-1:0]  out - remainder, held until the next result
//   div_zero             out - divisor was zero, held with results
module div_seq
    import div_pkg::*;
#(
    parameter int DEND_W = 14,
    parameter int SOR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DEND_W-1:0] dend,
    input  logic [SOR_W-1:0]  sor,
    output logic              busy,
    output logic              done,
    output logic [DEND_W-1:0] quo,
    output logic [SOR_W-1:0]  rem,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DEND_W + 1);
    localparam logic [DEND_W-1:0] QUO_DZ = ALL_ONES[DEND_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DEND_W - 1);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [DEND_W-1:0]  shreg_r;
    logic [SOR_W-1:0]   prem_r;
    logic [SOR_W-1:0]   sor_r;
    logic               fin_r;
    logic               busy_r;
    logic               done_r;
    logic [DEND_W-1:0]  quo_r;
    logic [SOR_W-1:0]   rem_r;
    logic               dz_r;
    logic               accept_s;
    logic               qbit_s;
    logic [SOR_W-1:0]   next_rem_s;

    // Start is only honoured when no division is in flight.
    assign accept_s = start && (state_r != RUN);

    div_step #(.SOR_W(SOR_W)) u_step (
        .partial_rem (prem_r),
        .dend_bit    (shreg_r[DEND_W-1]),
        .sor         (sor_r),
        .quo_bit     (qbit_s),
        .next_rem    (next_rem_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_s = (sor == {SOR_W{1'b0}}) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // fin_r marks that all DEND_W steps are done; this cycle commits results.
                if (fin_r) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Datapath: operand load, per-cycle restoring step, result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {DEND_W{1'b0}};
            prem_r  <= {SOR_W{1'b0}};
            sor_r   <= {SOR_W{1'b0}};
            fin_r   <= 1'b0;
            quo_r   <= {DEND_W{1'b0}};
            rem_r   <= {SOR_W{1'b0}};
            dz_r    <= 1'b0;
        end else if (accept_s) begin
            shreg_r <= dend;
            sor_r   <= sor;
            prem_r  <= {SOR_W{1'b0}};
            cnt_r   <= CNT_LOAD;
            fin_r   <= 1'b0;
            if (sor == {SOR_W{1'b0}}) begin
                // Zero divisor skips iteration; results land on the edge raising done.
                quo_r <= QUO_DZ;
                rem_r <= dend[SOR_W-1:0];
                dz_r  <= 1'b1;
            end else begin
                dz_r  <= 1'b0;
            end
        end else if (state_r == RUN) begin
            if (fin_r) begin
                quo_r <= shreg_r;
                rem_r <= prem_r;
            end else begin
                // Dividend bits leave the MSB while quotient bits enter the LSB.
                shreg_r <= {shreg_r[DEND_W-2:0], qbit_s};
                prem_r  <= next_rem_s;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    fin_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            fin_r <= fin_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quo      = quo_r;
    assign rem      = rem_r;
    assign div_zero = dz_r;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq (DEND_W=14, SOR_W=4).
// Expected results are computed by a behavioural model and queued when a start
// is driven; each done pulse pops and compares one entry.
module tb_div_seq;

    localparam int DEND_W = 14;
    localparam int SOR_W  = 4;

    typedef struct {
        logic [DEND_W-1:0] q;
        logic [SOR_W-1:0]  r;
        logic              dz;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DEND_W-1:0] dend;
    logic [SOR_W-1:0]  sor;
    logic              busy;
    logic              done;
    logic [DEND_W-1:0] quo;
    logic [SOR_W-1:0]  rem;
    logic              div_zero;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    div_seq #(.DEND_W(DEND_W), .SOR_W(SOR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dend     (dend),
        .sor      (sor),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [DEND_W-1:0] a, input logic [SOR_W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = 14'h3FFF;
            e.r  = a[SOR_W-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = DEND_W'(int'(a) / int'(b));
            e.r  = SOR_W'(int'(a) % int'(b));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse; returns in the first cycle after the accept edge.
    task automatic pulse_start(input logic [DEND_W-1:0] a, input logic [SOR_W-1:0] b, input bit push);
        dend  = a;
        sor   = b;
        start = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        dend  = $urandom_range(0, 16383);
        sor   = SOR_W'($urandom_range(0, 15));
    endtask

    // Wait for done (bounded), check latency if exp_lat>0, then pop and compare.
    task automatic finish_op(input string tag, input int cyc0, input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        if (done) begin
            if (exp_lat > 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
            chk({tag, "_busy_low"}, 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_quo"}, 32'(quo), 32'(e.q));
                chk({tag, "_rem"}, 32'(rem), 32'(e.r));
                chk({tag, "_dz"},  32'(div_zero), 32'(e.dz));
            end
        end
    endtask

    initial begin
        logic [DEND_W-1:0] hq;
        logic [SOR_W-1:0]  hr;
        int                extra;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        dend   = '0;
        sor    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quo",  32'(quo),  32'd0);
        chk("rst_rem",  32'(rem),  32'd0);
        chk("rst_dz",   32'(div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic divide with exact latency.
        pulse_start(14'd9999, 4'd7, 1'b1);
        chk("op1_busy", 32'(busy), 32'd1);
        finish_op("op1", 1, 16);
        @(negedge clk);
        chk("op1_pulse", 32'(done), 32'd0);
        chk("op1_hold_quo", 32'(quo), 32'd1428);

        pulse_start(14'd16383, 4'd15, 1'b1);
        finish_op("op2", 1, 16);
        @(negedge clk);
        pulse_start(14'd5, 4'd9, 1'b1);
        finish_op("op3", 1, 16);
        @(negedge clk);
        pulse_start(14'd0, 4'd3, 1'b1);
        finish_op("op_zero_dend", 1, 16);
        @(negedge clk);

        // Divide by zero, then a valid divide clears div_zero.
        pulse_start(14'h1234, 4'd0, 1'b1);
        finish_op("dz", 1, 1);
        @(negedge clk);
        chk("dz_hold", 32'(div_zero), 32'd1);
        pulse_start(14'd50, 4'd7, 1'b1);
        finish_op("dz_clear", 1, 16);
        @(negedge clk);

        // Start during RUN is ignored.
        pulse_start(14'd9999, 4'd7, 1'b1);
        repeat (3) @(negedge clk);
        pulse_start(14'd1000, 4'd3, 1'b0);
        finish_op("ignore", 5, 16);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ignore_one_done", 32'(extra), 32'd0);

        // Back-to-back: start held in the DONE cycle.
        pulse_start(14'd9999, 4'd7, 1'b1);
        finish_op("b2b_first", 1, 16);
        hq = quo;
        hr = rem;
        pulse_start(14'd100, 4'd10, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold_quo", 32'(quo), 32'(hq));
        chk("b2b_hold_rem", 32'(rem), 32'(hr));
        finish_op("b2b_second", 1, 16);
        @(negedge clk);

        // Reset in the middle of a run aborts without done.
        pulse_start(14'd12345, 4'd11, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quo",  32'(quo),  32'd0);
        chk("abort_rem",  32'(rem),  32'd0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort_no_done", 32'(extra), 32'd0);
        pulse_start(14'd12345, 4'd11, 1'b1);
        finish_op("after_abort", 1, 16);
        @(negedge clk);

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            logic [DEND_W-1:0] a;
            logic [SOR_W-1:0]  b;
            a = DEND_W'($urandom_range(0, 16383));
            b = SOR_W'($urandom_range(0, 15));
            pulse_start(a, b, 1'b1);
            finish_op("rand", 1, (b == '0) ? 1 : 16);
            @(negedge clk);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
